rtc_bus_master: RTL and testbench

Bus-master controller for the multiplexed address/data RTC interface. It converts single-byte read and write requests from FPGA logic into the full strobe sequence: an address cycle followed by a data cycle on the 8-bit shared bus. It sits between the clock/alarm control logic and the RTC chip pins and is the initiating end of the RTC register protocol. All bus timing is derived from the system clock in programmable phase lengths.

---
 rtl/rtc_bus_master.sv | 193 +++++++++++++++++++
 tb/tb_rtc_bus_master.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_master.sv
// Bus master for the multiplexed address/data RTC interface: one byte per request, address cycle then data cycle.
// Optional build macro RTC_ADDR_CACHE_EN skips the address cycle when the address repeats the last completed one.
module rtc_bus_master #(
  parameter int unsigned PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  inout  wire  [7:0] DatAdd
);

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE
  } state_t;

  localparam logic [7:0] RELOAD = 8'(PHASE_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ad_q, ad_d, cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic       oe_q, oe_d, busy_q, busy_d, done_q, done_d;
  logic [7:0] dout_q, dout_d;
  logic       phase_end;
  logic       skip_addr;

`ifdef RTC_ADDR_CACHE_EN
  logic [7:0] last_addr_q, last_addr_d;
  logic       valid_q, valid_d;
  assign skip_addr = valid_q && (addr == last_addr_q);
`else
  assign skip_addr = 1'b0;
`endif

  assign phase_end = (cnt_q == 8'd0);

  // Next-state sequencing, request latching and read capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef RTC_ADDR_CACHE_EN
    last_addr_d = last_addr_q;
    valid_d     = valid_q;
`endif
    if (state_q == IDLE || state_q == DONE) begin
      cnt_d = RELOAD;
    end else if (phase_end) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - 8'd1;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          rw_d    = rw;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = skip_addr ? D_SETUP : A_SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      A_SETUP:  state_d = phase_end ? A_STROBE : A_SETUP;
      A_STROBE: state_d = phase_end ? A_HOLD   : A_STROBE;
      A_HOLD:   state_d = phase_end ? GAP      : A_HOLD;
      GAP:      state_d = phase_end ? D_SETUP  : GAP;
      D_SETUP:  state_d = phase_end ? D_STROBE : D_SETUP;
      D_STROBE: begin
        if (phase_end) begin
          state_d = D_HOLD;
          rdata_d = rw_q ? DatAdd : rdata_q;
        end else begin
          state_d = D_STROBE;
        end
      end
      D_HOLD:   state_d = phase_end ? DONE : D_HOLD;
      DONE: begin
        state_d = IDLE;
`ifdef RTC_ADDR_CACHE_EN
        valid_d     = 1'b1;
        last_addr_d = addr_q;
`endif
      end
      default:  state_d = IDLE;
    endcase
  end

  // Bus pin decode for the state being entered, so every pin comes straight from a flop
  always_comb begin
    ad_d   = 1'b1;
    cs_d   = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    oe_d   = 1'b0;
    dout_d = 8'h00;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_d)
      IDLE:     busy_d = 1'b0;
      A_SETUP, A_HOLD: begin
        cs_d = 1'b0; ad_d = 1'b0; oe_d = 1'b1; dout_d = addr_d;
      end
      A_STROBE: begin
        cs_d = 1'b0; ad_d = 1'b0; oe_d = 1'b1; dout_d = addr_d; wr_d = 1'b0;
      end
      GAP:      cs_d = 1'b1;
      D_SETUP, D_HOLD: begin
        cs_d = 1'b0; oe_d = ~rw_d; dout_d = wdata_d;
      end
      D_STROBE: begin
        cs_d = 1'b0; oe_d = ~rw_d; dout_d = wdata_d;
        rd_d = ~rw_d; wr_d = rw_d;
      end
      DONE:     done_d = 1'b1;
      default:  busy_d = 1'b0;
    endcase
  end

  // State, datapath and pin registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      ad_q    <= 1'b1;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ad_q    <= ad_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef RTC_ADDR_CACHE_EN
  // Last-address cache, only meaningful after a completed transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_addr_q <= 8'h00;
      valid_q     <= 1'b0;
    end else begin
      last_addr_q <= last_addr_d;
      valid_q     <= valid_d;
    end
  end
`endif

  assign DatAdd = oe_q ? dout_q : 8'hzz;
  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign AD     = ad_q;
  assign CS     = cs_q;
  assign RD     = rd_q;
  assign WR     = wr_q;

endmodule

// File: tb/tb_rtc_bus_master.sv
// Self-checking bench for rtc_bus_master: two instances (PHASE_CYC=4 and 1) against a cycle-offset reference model.
module tb_rtc_bus_master;

  logic clk = 1'b0;
  logic reset;

  logic       start_0, rw_0, busy_0, done_0, ad_0, cs_0, rd_0, wr_0;
  logic [7:0] addr_0, wdata_0, rdata_0, rtc_0;
  wire  [7:0] dat_0;
  logic       start_1, rw_1, busy_1, done_1, ad_1, cs_1, rd_1, wr_1;
  logic [7:0] addr_1, wdata_1, rdata_1, rtc_1;
  wire  [7:0] dat_1;

  int cmp = 0;
  int errs = 0;
  logic [7:0] last_rd [2];
  bit         valid [2];
  logic [7:0] last_a [2];

  rtc_bus_master #(.PHASE_CYC(4)) u4 (
    .clk(clk), .reset(reset), .start(start_0), .rw(rw_0), .addr(addr_0), .wdata(wdata_0),
    .rdata(rdata_0), .busy(busy_0), .done(done_0), .AD(ad_0), .CS(cs_0), .RD(rd_0), .WR(wr_0),
    .DatAdd(dat_0));

  rtc_bus_master #(.PHASE_CYC(1)) u1 (
    .clk(clk), .reset(reset), .start(start_1), .rw(rw_1), .addr(addr_1), .wdata(wdata_1),
    .rdata(rdata_1), .busy(busy_1), .done(done_1), .AD(ad_1), .CS(cs_1), .RD(rd_1), .WR(wr_1),
    .DatAdd(dat_1));

  // RTC chip model: drives the bus only while its read strobe is low
  assign dat_0 = (rd_0 === 1'b0) ? rtc_0 : 8'hzz;
  assign dat_1 = (rd_1 === 1'b0) ? rtc_1 : 8'hzz;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int t, input logic [7:0] obs, input logic [7:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s t=%0d: observed %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input bit s, input bit r, input logic [7:0] a, input logic [7:0] wd);
    if (sel == 1) begin
      start_1 = s; rw_1 = r; addr_1 = a; wdata_1 = wd;
    end else begin
      start_0 = s; rw_0 = r; addr_0 = a; wdata_0 = wd;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      last_rd[i] = 8'h00;
      valid[i]   = 1'b0;
      last_a[i]  = 8'h00;
    end
  endtask

  task automatic chk_idle_pins(input int sel, input string tag, input logic [7:0] exp_rdata);
    chk({tag, "_AD"},   -1, {7'd0, sel ? ad_1 : ad_0}, 8'd1);
    chk({tag, "_CS"},   -1, {7'd0, sel ? cs_1 : cs_0}, 8'd1);
    chk({tag, "_RD"},   -1, {7'd0, sel ? rd_1 : rd_0}, 8'd1);
    chk({tag, "_WR"},   -1, {7'd0, sel ? wr_1 : wr_0}, 8'd1);
    chk({tag, "_DAT"},  -1, sel ? dat_1 : dat_0, 8'hzz);
    chk({tag, "_BUSY"}, -1, {7'd0, sel ? busy_1 : busy_0}, 8'd0);
    chk({tag, "_DONE"}, -1, {7'd0, sel ? done_1 : done_0}, 8'd0);
    chk({tag, "_RDATA"}, -1, sel ? rdata_1 : rdata_0, exp_rdata);
  endtask

  // Asynchronous reset pulse between clock edges; called at a falling edge
  task automatic async_reset(input int sel, input string tag);
    #1 reset = 1'b0;
    #1 chk_idle_pins(sel, tag, 8'h00);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One transaction; expected pins come from the cycle offset t after the accepting edge
  task automatic txn(input int sel, input bit r, input logic [7:0] a, input logic [7:0] wd,
                     input logic [7:0] rv, input bit restart, input int abort_t);
    int p, n, ph, base;
    bit hit;
    bit e_ad, e_cs, e_rd, e_wr, e_busy, e_done;
    logic [7:0] e_dat, e_rdata;
    p = (sel == 1) ? 1 : 4;
`ifdef RTC_ADDR_CACHE_EN
    hit = valid[sel] && (last_a[sel] == a);
`else
    hit = 1'b0;
`endif
    base = hit ? 4 : 0;
    n    = hit ? 3 * p : 7 * p;
    if (sel == 1) rtc_1 = rv; else rtc_0 = rv;
    drive(sel, 1'b1, r, a, wd);
    for (int t = 0; t <= n + 1; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (t == n + 1)  ph = 8;
      else if (t == n) ph = 7;
      else             ph = base + t / p;
      e_ad   = !(ph <= 2);
      e_cs   = (ph == 3) || (ph >= 7);
      e_wr   = !(ph == 1 || (ph == 5 && !r));
      e_rd   = !(ph == 5 && r);
      e_busy = (ph <= 7);
      e_done = (ph == 7);
      if (ph <= 2)                        e_dat = a;
      else if (ph >= 4 && ph <= 6 && !r)  e_dat = wd;
      else if (ph == 5 && r)              e_dat = rv;
      else                                e_dat = 8'hzz;
      e_rdata = (r && ph >= 6) ? rv : last_rd[sel];
      chk("AD",    t, {7'd0, sel ? ad_1 : ad_0},     {7'd0, e_ad});
      chk("CS",    t, {7'd0, sel ? cs_1 : cs_0},     {7'd0, e_cs});
      chk("RD",    t, {7'd0, sel ? rd_1 : rd_0},     {7'd0, e_rd});
      chk("WR",    t, {7'd0, sel ? wr_1 : wr_0},     {7'd0, e_wr});
      chk("BUSY",  t, {7'd0, sel ? busy_1 : busy_0}, {7'd0, e_busy});
      chk("DONE",  t, {7'd0, sel ? done_1 : done_0}, {7'd0, e_done});
      chk("DAT",   t, sel ? dat_1 : dat_0, e_dat);
      chk("RDATA", t, sel ? rdata_1 : rdata_0, e_rdata);
      if (t == 0) begin
        drive(sel, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
      end
      if (restart && t == 4) drive(sel, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
      if (restart && t == 5) drive(sel, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
      if (t == abort_t) begin
        async_reset(sel, "ABORT");
        return;
      end
    end
    if (r) last_rd[sel] = rv;
    valid[sel]  = 1'b1;
    last_a[sel] = a;
  endtask

  initial begin
    bit r;
    int sel;
    logic [7:0] a;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    rtc_0 = 8'h00;
    rtc_1 = 8'h00;
    model_reset();
    #2 reset = 1'b0;
    #1 chk_idle_pins(0, "RST0", 8'h00);
    chk_idle_pins(1, "RST1", 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    txn(0, 1'b0, 8'h21, 8'h45, 8'h00, 1'b0, -1);
    txn(0, 1'b1, 8'h23, 8'h00, 8'h9A, 1'b0, -1);
    txn(0, 1'b0, 8'h5A, 8'h3C, 8'h00, 1'b1, -1);
    txn(0, 1'b1, 8'h66, 8'h11, 8'hC3, 1'b0, -1);
    txn(0, 1'b0, 8'h77, 8'h88, 8'h00, 1'b0, 5);
    txn(0, 1'b0, 8'h21, 8'h45, 8'h00, 1'b0, -1);
    txn(0, 1'b0, 8'h21, 8'h46, 8'h00, 1'b0, -1);
    @(negedge clk);
    async_reset(0, "MIDRST");
    txn(0, 1'b0, 8'h21, 8'h47, 8'h00, 1'b0, -1);
    txn(1, 1'b0, 8'h0F, 8'hF0, 8'h00, 1'b0, -1);
    txn(1, 1'b1, 8'h0F, 8'h00, 8'h5E, 1'b0, -1);
    txn(1, 1'b1, 8'h30, 8'h00, 8'hA5, 1'b0, -1);

    for (int i = 0; i < 14; i++) begin
      sel = int'($urandom_range(1, 0));
      r   = 1'($urandom);
      a   = ($urandom_range(2, 0) == 0) ? 8'h21 : 8'($urandom);
      txn(sel, r, a, 8'($urandom), 8'($urandom), (sel == 0) && ($urandom_range(1, 0) == 1), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
